// File: rtl/norm_dist_pn_pos_sum_pipe_pkg.sv
// rtl/norm_dist_pn_pos_sum_pipe_pkg.sv - shared defaults for the normalizing sum pipeline
`ifndef FPU_COMMON_SVH
`include "fpu_common.sv"
`endif

package norm_dist_pn_pos_sum_pipe_pkg;
    localparam int DEFAULT_N    = 24;
    localparam int DEFAULT_SIZE = 50;
endpackage

// File: rtl/fpu_common.sv
// rtl/fpu_common.sv - shared FPU helper macros
`ifndef FPU_COMMON_SVH
`define FPU_COMMON_SVH

`define ceilLog2(x) ($clog2(x))

`endif

// File: rtl/norm_dist_pn_pos_sum_pipe_est.sv
// rtl/norm_dist_pn_pos_sum_pipe_est.sv - leading-one distance estimate for a positive sum a+b
`ifndef FPU_COMMON_SVH
`include "fpu_common.sv"
`endif

module estNormDistPNPosSumS
    import norm_dist_pn_pos_sum_pipe_pkg::*;
#(
    parameter int N    = DEFAULT_N,
    parameter int size = DEFAULT_SIZE,
    localparam int normDistSize = `ceilLog2(size + N)
) (
    input  logic [size-1:0]         a,
    input  logic [size-1:0]         b,
    output logic [normDistSize-1:0] est
);

    logic [size-1:0] key;

    // The key's top set bit lands on the sum's leading one or one position above it.
    always_comb begin
        key = (a ^ b) ^ ((a | b) << 1);
        est = normDistSize'(N + size - 1);
        for (int i = 0; i < size; i++) begin
            if (i > 0 && key[i]) begin
                est = normDistSize'(N + size - 1 - i);
            end
        end
    end

endmodule

// File: rtl/norm_dist_pn_pos_sum_pipe.sv
// rtl/norm_dist_pn_pos_sum_pipe.sv - two-stage add-and-normalize pipeline with valid/ready handshake
`ifndef FPU_COMMON_SVH
`include "fpu_common.sv"
`endif

module norm_dist_pn_pos_sum_pipe
    import norm_dist_pn_pos_sum_pipe_pkg::*;
#(
    parameter int N    = DEFAULT_N,
    parameter int size = DEFAULT_SIZE,
    localparam int normDistSize = `ceilLog2(size + N)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [size-1:0]         a,
    input  logic [size-1:0]         b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [size-1:0]         sigOut,
    output logic [normDistSize-1:0] normDist,
    output logic                    isZero
);

    logic                    s1_valid;
    logic [size-1:0]         s1_sum;
    logic [normDistSize-1:0] s1_est;
    logic [normDistSize-1:0] est;
    logic                    s1_ready;
    logic                    s2_ready;
    logic                    accept;

    logic [normDistSize-1:0] shift_amt;
    logic [size-1:0]         coarse;
    logic                    fix;
    logic [size-1:0]         norm_sig;
    logic [normDistSize-1:0] norm_dist;
    logic                    norm_zero;

    estNormDistPNPosSumS #(
        .N    (N),
        .size (size)
    ) u_est (
        .a   (a),
        .b   (b),
        .est (est)
    );

    assign s2_ready = !out_valid || out_ready;
    assign s1_ready = !s1_valid || s2_ready;
    assign in_ready = s1_ready;
    assign accept   = in_valid && s1_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else if (s1_ready) begin
            s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            s1_sum <= a + b;
            s1_est <= est;
        end
    end

    // The estimate may fall one short of the leading one; a single extra shift covers it.
    always_comb begin
        shift_amt = s1_est - normDistSize'(N);
        coarse    = s1_sum << shift_amt;
        fix       = !coarse[size-1] && (shift_amt < normDistSize'(size - 1));
        norm_sig  = fix ? (coarse << 1) : coarse;
        norm_dist = fix ? (s1_est + normDistSize'(1)) : s1_est;
        norm_zero = (s1_sum == '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            sigOut    <= '0;
            normDist  <= '0;
            isZero    <= 1'b0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sigOut   <= norm_sig;
                normDist <= norm_dist;
                isZero   <= norm_zero;
            end
        end
    end

endmodule

// File: tb/tb_norm_dist_pn_pos_sum_pipe.sv
// tb/tb_norm_dist_pn_pos_sum_pipe.sv - directed self-checking bench for norm_dist_pn_pos_sum_pipe
module tb_norm_dist_pn_pos_sum_pipe;

    localparam int SZ = 50;
    localparam int W  = 7;

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [SZ-1:0] a;
    logic [SZ-1:0] b;
    logic          out_valid;
    logic          out_ready;
    logic [SZ-1:0] sigOut;
    logic [W-1:0]  normDist;
    logic          isZero;

    int total = 0;
    int bad   = 0;

    norm_dist_pn_pos_sum_pipe dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sigOut    (sigOut),
        .normDist  (normDist),
        .isZero    (isZero)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic test_reset;
        #1;
        repeat (2) @(posedge clock);
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_out_valid got=%b want=0", out_valid);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
        total++;
        if (sigOut !== '0 || normDist !== '0 || isZero !== 1'b0) begin
            bad++;
            $display("FAIL reset_data got=%h/%0d/%b want=0/0/0", sigOut, normDist, isZero);
        end
        #2 reset = 1'b0;
    endtask

    task automatic test_directed;
        logic [SZ-1:0] va [5];
        logic [SZ-1:0] vb [5];
        logic [SZ-1:0] vs [5];
        logic [W-1:0]  vd [5];
        logic          vz [5];
        va[0] = 50'd1;                 vb[0] = 50'd0;
        vs[0] = 50'h2_0000_0000_0000;  vd[0] = 7'd73; vz[0] = 1'b0;
        va[1] = 50'h1_0000_0000_0000;  vb[1] = 50'h1_0000_0000_0000;
        vs[1] = 50'h2_0000_0000_0000;  vd[1] = 7'd24; vz[1] = 1'b0;
        va[2] = 50'd0;                 vb[2] = 50'd0;
        vs[2] = 50'd0;                 vd[2] = 7'd73; vz[2] = 1'b1;
        va[3] = 50'd3;                 vb[3] = 50'd0;
        vs[3] = 50'h3_0000_0000_0000;  vd[3] = 7'd72; vz[3] = 1'b0;
        va[4] = 50'h2_0000_0000_0000;  vb[4] = 50'd0;
        vs[4] = 50'h2_0000_0000_0000;  vd[4] = 7'd24; vz[4] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            a = va[i]; b = vb[i]; in_valid = 1'b1; out_ready = 1'b1;
            #1;
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL directed%0d_in_ready got=%b want=1", i, in_ready);
            end
            @(posedge clock);
            #1;
            in_valid = 1'b0;
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL directed%0d_early_valid got=%b want=0", i, out_valid);
            end
            @(posedge clock);
            #1;
            total++;
            if (out_valid !== 1'b1 || sigOut !== vs[i] || normDist !== vd[i] || isZero !== vz[i]) begin
                bad++;
                $display("FAIL directed%0d_result got=%b/%h/%0d/%b want=1/%h/%0d/%b",
                         i, out_valid, sigOut, normDist, isZero, vs[i], vd[i], vz[i]);
            end
        end
        @(posedge clock);
    endtask

    task automatic test_back_to_back;
        logic [SZ-1:0] ta [10];
        logic [SZ-1:0] tb [10];
        logic [SZ-1:0] ts [10];
        logic [W-1:0]  td [10];
        logic          tz [10];
        logic [31:0]   rdy_pat;
        int  sent, got, inflight, cyc, low_seen;
        logic acc, con, prev_stall, exp_ready;
        ta[0] = 50'd1;               tb[0] = 50'd1;               ts[0] = 50'h2_0000_0000_0000; td[0] = 7'd72;
        ta[1] = 50'd5;               tb[1] = 50'd3;               ts[1] = 50'h2_0000_0000_0000; td[1] = 7'd70;
        ta[2] = 50'd0;               tb[2] = 50'd6;               ts[2] = 50'h3_0000_0000_0000; td[2] = 7'd71;
        ta[3] = 50'd100;             tb[3] = 50'd28;              ts[3] = 50'h2_0000_0000_0000; td[3] = 7'd66;
        ta[4] = 50'd0;               tb[4] = 50'd1;               ts[4] = 50'h2_0000_0000_0000; td[4] = 7'd73;
        ta[5] = 50'h4000_0000;       tb[5] = 50'h4000_0000;       ts[5] = 50'h2_0000_0000_0000; td[5] = 7'd42;
        ta[6] = 50'd7;               tb[6] = 50'd0;               ts[6] = 50'h3_8000_0000_0000; td[6] = 7'd71;
        ta[7] = 50'h1_0000_0000_0000; tb[7] = 50'h0_FFFF_FFFF_FFFF; ts[7] = 50'h3_FFFF_FFFF_FFFE; td[7] = 7'd25;
        ta[8] = 50'd0;               tb[8] = 50'd0;               ts[8] = 50'd0;                td[8] = 7'd73;
        ta[9] = 50'd12;              tb[9] = 50'd4;               ts[9] = 50'h2_0000_0000_0000; td[9] = 7'd69;
        for (int i = 0; i < 10; i++) tz[i] = (i == 8);
        rdy_pat = 32'hB3C5_1E6D;
        sent = 0; got = 0; inflight = 0; cyc = 0; low_seen = 0;
        prev_stall = 1'b0;
        @(posedge clock);
        while (got < 10 && cyc < 200) begin
            #1;
            out_ready = rdy_pat[cyc % 32];
            if (sent < 10) begin
                in_valid = 1'b1; a = ta[sent]; b = tb[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            exp_ready = !(inflight == 2 && !out_ready);
            total++;
            if (in_ready !== exp_ready) begin
                bad++;
                $display("FAIL b2b_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, exp_ready);
            end
            if (prev_stall) begin
                total++;
                if (out_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_hold cyc=%0d got=%b want=1", cyc, out_valid);
                end
            end
            if (!in_ready) low_seen++;
            acc = in_valid && in_ready;
            con = out_valid && out_ready;
            if (con) begin
                total++;
                if (sigOut !== ts[got] || normDist !== td[got] || isZero !== tz[got]) begin
                    bad++;
                    $display("FAIL b2b_result%0d got=%h/%0d/%b want=%h/%0d/%b",
                             got, sigOut, normDist, isZero, ts[got], td[got], tz[got]);
                end
            end
            prev_stall = out_valid && !out_ready;
            @(posedge clock);
            if (acc) begin sent++; inflight++; end
            if (con) begin got++; inflight--; end
            cyc++;
        end
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        total++;
        if (got != 10) begin
            bad++;
            $display("FAIL b2b_count got=%0d want=10", got);
        end
        total++;
        if (low_seen == 0) begin
            bad++;
            $display("FAIL b2b_backpressure got=%0d want>0", low_seen);
        end
        @(posedge clock);
    endtask

    task automatic test_reset_mid;
        @(posedge clock);
        #1;
        out_ready = 1'b0; in_valid = 1'b1; a = 50'd5; b = 50'd3;
        @(posedge clock);
        #1;
        a = 50'd7; b = 50'd0;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_full got=%b/%b want=1/0", out_valid, in_ready);
        end
        #1 reset = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_async_clear got=%b/%b want=0/1", out_valid, in_ready);
        end
        total++;
        if (sigOut !== '0 || normDist !== '0 || isZero !== 1'b0) begin
            bad++;
            $display("FAIL mid_data_clear got=%h/%0d/%b want=0/0/0", sigOut, normDist, isZero);
        end
        #1 reset = 1'b0;
        @(posedge clock);
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_stale got=%b want=0", out_valid);
        end
        out_ready = 1'b1; in_valid = 1'b1; a = 50'd12; b = 50'd4;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_early_valid got=%b want=0", out_valid);
        end
        @(posedge clock);
        #1;
        total++;
        if (out_valid !== 1'b1 || sigOut !== 50'h2_0000_0000_0000 || normDist !== 7'd69 || isZero !== 1'b0) begin
            bad++;
            $display("FAIL mid_result got=%b/%h/%0d/%b want=1/2000000000000/69/0",
                     out_valid, sigOut, normDist, isZero);
        end
        @(posedge clock);
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_duplicate got=%b want=0", out_valid);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        test_reset;
        test_directed;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
